seven_seg_scan: RTL and testbench

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

---
 rtl/seven_seg_scan.sv | 107 ++++++++++
 tb/tb_seven_seg_scan.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment scanner with shadowed, frame-aligned display updates.
// Define SEVEN_SEG_LZ_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seven_seg_scan #(
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic [15:0] value_i,
    input  logic        load_i,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        frame_o
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      shadow;
    logic [15:0]      disp;
    logic             pending;

    logic       tick;
    logic       wrap;
    logic [3:0] nib;
    logic [3:0] lz;
    logic [3:0] an_nxt;

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == 2'd3);
    assign nib  = disp[{idx, 2'b00} +: 4];

`ifdef SEVEN_SEG_LZ_BLANK_EN
    // A digit is a leading zero when it and every more significant nibble are zero.
    assign lz[0] = 1'b0;
    assign lz[1] = (disp[15:4]  == 12'h000);
    assign lz[2] = (disp[15:8]  == 8'h00);
    assign lz[3] = (disp[15:12] == 4'h0);
`else
    assign lz = 4'b0000;
`endif

    always_comb begin
        an_nxt = 4'hF;
        if (cnt >= CNT_BLANK && !lz[idx])
            an_nxt = ~(4'b0001 << idx);
    end

    // Scan state plus output register stage: outputs lag the scan state by one cycle.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            cnt     <= '0;
            idx     <= 2'd0;
            shadow  <= 16'h0000;
            disp    <= 16'h0000;
            pending <= 1'b0;
            AN      <= 4'hF;
            SEG     <= 7'h7F;
            frame_o <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
                idx <= idx + 2'd1;

            // Transfer uses the pre-edge shadow; a coincident load re-arms pending.
            frame_o <= wrap && pending;
            if (wrap && pending) begin
                disp    <= shadow;
                pending <= 1'b0;
            end
            if (load_i) begin
                shadow  <= value_i;
                pending <= 1'b1;
            end

            AN  <= an_nxt;
            SEG <= hex_to_seg(nib);
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with TICK_DIV=8, BLANK_CYCLES=2.
module tb_seven_seg_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value_i = 16'h0000;
    logic        load_i = 1'b0;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        frame_o;

    int total = 0;
    int bad   = 0;
    int edges = 0;

    seven_seg_scan #(.TICK_DIV(8), .BLANK_CYCLES(2)) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .value_i   (value_i),
        .load_i    (load_i),
        .AN        (AN),
        .SEG       (SEG),
        .frame_o   (frame_o)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // State s = edges completed before the output-producing edge.
    function automatic logic [3:0] an_of(input int s, input logic [15:0] d);
        int c;
        int k;
        logic [15:0] hi;
        c  = s % 8;
        k  = (s / 8) % 4;
        hi = d >> (4 * k);
        if (c < 2) return 4'hF;
`ifdef SEVEN_SEG_LZ_BLANK_EN
        if (k >= 1 && hi == 16'h0000) return 4'hF;
`endif
        return ~(4'b0001 << k);
    endfunction

    task automatic check_out(input string tag, input logic [3:0] an_e,
                             input logic [6:0] seg_e, input logic frm_e);
        total++;
        assert (AN === an_e) else begin
            bad++;
            $error("FAIL %s AN: got %b want %b (edge %0d)", tag, AN, an_e, edges);
        end
        total++;
        assert (SEG === seg_e) else begin
            bad++;
            $error("FAIL %s SEG: got %b want %b (edge %0d)", tag, SEG, seg_e, edges);
        end
        total++;
        assert (frame_o === frm_e) else begin
            bad++;
            $error("FAIL %s frame_o: got %b want %b (edge %0d)", tag, frame_o, frm_e, edges);
        end
    endtask

    // One clock: drive at negedge, clock, sample at the following negedge.
    task automatic cyc(input bit ld, input logic [15:0] v, input logic [15:0] dsp,
                       input bit frm, input string tag);
        int s;
        int k;
        load_i  = ld;
        value_i = v;
        @(posedge clk);
        edges++;
        @(negedge clk);
        load_i = 1'b0;
        s = edges - 1;
        k = (s / 8) % 4;
        check_out(tag, an_of(s, dsp), seg_of(dsp[4*k +: 4]), frm);
    endtask

    task automatic run(input int n, input logic [15:0] dsp, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, dsp, 1'b0, tag);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_out("reset", 4'hF, 7'h7F, 1'b0);

        rst_n = 1'b1;
        edges = 0;
        run(32, 16'h0000, "idle_scan");

        run(5, 16'h0000, "pre_load");
        cyc(1'b1, 16'h1A2F, 16'h0000, 1'b0, "load_1a2f");
        run(25, 16'h0000, "hold_old");
        cyc(1'b0, 16'h0000, 16'h0000, 1'b1, "wrap_1a2f");
        run(32, 16'h1A2F, "show_1a2f");

        run(3, 16'h1A2F, "pre_dbl");
        cyc(1'b1, 16'h1234, 16'h1A2F, 1'b0, "load_1234");
        run(4, 16'h1A2F, "mid_dbl");
        cyc(1'b1, 16'h5678, 16'h1A2F, 1'b0, "load_5678");
        run(22, 16'h1A2F, "hold_dbl");
        cyc(1'b0, 16'h0000, 16'h1A2F, 1'b1, "wrap_5678");
        run(32, 16'h5678, "show_5678");

        run(10, 16'h5678, "pre_00ff");
        cyc(1'b1, 16'h00FF, 16'h5678, 1'b0, "load_00ff");
        run(20, 16'h5678, "hold_00ff");
        cyc(1'b1, 16'hBEEF, 16'h5678, 1'b1, "wrap_load_beef");
        run(31, 16'h00FF, "show_00ff");
        cyc(1'b0, 16'h0000, 16'h00FF, 1'b1, "wrap_beef");
        run(32, 16'hBEEF, "show_beef");

        run(3, 16'hBEEF, "pre_rst");
        cyc(1'b1, 16'h1234, 16'hBEEF, 1'b0, "load_pending");
        run(16, 16'hBEEF, "to_digit2");
        #2 rst_n = 1'b0;
        #1 check_out("async_rst", 4'hF, 7'h7F, 1'b0);
        @(negedge clk);
        check_out("rst_hold", 4'hF, 7'h7F, 1'b0);
        rst_n = 1'b1;
        edges = 0;
        run(32, 16'h0000, "after_rst");
        run(32, 16'h0000, "no_stale");

        run(4, 16'h0000, "pre_00f0");
        cyc(1'b1, 16'h00F0, 16'h0000, 1'b0, "load_00f0");
        run(26, 16'h0000, "hold_00f0");
        cyc(1'b0, 16'h0000, 16'h0000, 1'b1, "wrap_00f0");
        run(32, 16'h00F0, "show_00f0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
